// File: rtl/contador_pkg.sv
// Shared definitions for the two-digit BCD counter and its controller.
package contador_pkg;

  localparam int BCD_W        = 4;
  localparam int VALOR_W      = 7;
  localparam int CONTADOR_MAX = 99;
  localparam int CONTADOR_MIN = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    CLEAR = 3'd2,
    REPOR = 3'd3,
    WAIT  = 3'd4
  } estado_t;

endpackage

// File: rtl/controlador_contador_detector_pedido.sv
// Request edge detector with a one-deep pending latch; a new edge is dropped
// while the flag is already set.
module detector_pedido (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic clr,
  output logic pendente
);

  logic req_q;

  // NOTE: sequential state is always written with <= so every register samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q    <= 1'b0;
      pendente <= 1'b0;
    end else begin
      req_q <= req;
      if (clr)                pendente <= 1'b0;
      else if (req && !req_q) pendente <= 1'b1;
    end
  end

endmodule

// File: rtl/controlador_contador.sv
// Sequencing/arbitration controller for the BCD 0-99 counter.
// Define CONTROLADOR_REPOR_EN to compile in the automatic refill burst.
module controlador_contador
  import contador_pkg::*;
#(
  parameter int STEP_GAP     = 1,
  parameter int REPOR_LIMIT  = 5,
  parameter int REPOR_TARGET = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_inc,
  input  logic             req_dec,
  input  logic             req_zera,
  input  logic             auto_repor,
  input  logic [BCD_W-1:0] unid,
  input  logic [BCD_W-1:0] dezena,
  output logic             passo,
  output logic             sentido,
  output logic             zera,
  output logic             negado,
  output logic             ocupado
);

  localparam int CW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

  estado_t               estado_q, estado_d;
  logic [CW-1:0]         espera_q, espera_d;
  logic                  rr_dec_q, rr_dec_d;
  logic                  rajada_q, rajada_d;
  logic                  passo_d, sentido_d, zera_d, negado_d;
  logic                  pend_inc, pend_dec, pend_zera;
  logic                  clr_inc, clr_dec, clr_zera;
  logic                  decidir, repor_dispara, rajada_continua;
  logic [VALOR_W-1:0]    valor;

  assign valor = VALOR_W'(dezena) * VALOR_W'(10) + VALOR_W'(unid);

  detector_pedido u_det_inc  (.clock(clock), .reset(reset), .req(req_inc),
                              .clr(clr_inc),  .pendente(pend_inc));
  detector_pedido u_det_dec  (.clock(clock), .reset(reset), .req(req_dec),
                              .clr(clr_dec),  .pendente(pend_dec));
  detector_pedido u_det_zera (.clock(clock), .reset(reset), .req(req_zera),
                              .clr(clr_zera), .pendente(pend_zera));

`ifdef CONTROLADOR_REPOR_EN
  assign repor_dispara   = auto_repor && (valor < VALOR_W'(REPOR_LIMIT));
  assign rajada_continua = rajada_q && auto_repor && !pend_zera &&
                           (valor != VALOR_W'(REPOR_TARGET));
`else
  logic unused_repor;
  assign unused_repor    = ^{auto_repor, REPOR_LIMIT, REPOR_TARGET};
  assign repor_dispara   = 1'b0;
  assign rajada_continua = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    estado_d  = estado_q;
    espera_d  = espera_q;
    rr_dec_d  = rr_dec_q;
    rajada_d  = rajada_q;
    passo_d   = 1'b0;
    sentido_d = 1'b0;
    zera_d    = 1'b0;
    negado_d  = 1'b0;
    clr_inc   = 1'b0;
    clr_dec   = 1'b0;
    clr_zera  = 1'b0;
    decidir   = 1'b0;

    unique case (estado_q)
      IDLE: decidir = 1'b1;
      STEP, CLEAR, REPOR: begin
        estado_d = WAIT;
        espera_d = CW'(STEP_GAP - 1);
      end
      WAIT: begin
        if (espera_q != '0) begin
          espera_d = espera_q - CW'(1);
        end else if (rajada_continua) begin
          estado_d  = REPOR;
          passo_d   = 1'b1;
          sentido_d = 1'b1;
        end else begin
          // The last gap cycle decides directly so back-to-back work keeps
          // the STEP_GAP+1 strobe spacing.
          rajada_d = 1'b0;
          decidir  = 1'b1;
        end
      end
      default: estado_d = IDLE;
    endcase

    if (decidir) begin
      estado_d = IDLE;
      if (pend_zera) begin
        estado_d = CLEAR;
        zera_d   = 1'b1;
        clr_zera = 1'b1;
        clr_inc  = 1'b1;
        clr_dec  = 1'b1;
      end else if (repor_dispara) begin
        estado_d  = REPOR;
        passo_d   = 1'b1;
        sentido_d = 1'b1;
        rajada_d  = 1'b1;
      end else if (pend_inc || pend_dec) begin
        estado_d = STEP;
        rr_dec_d = !rr_dec_q;
        if (pend_inc && (!pend_dec || !rr_dec_q)) begin
          clr_inc = 1'b1;
          if (valor == VALOR_W'(CONTADOR_MAX)) negado_d = 1'b1;
          else begin
            passo_d   = 1'b1;
            sentido_d = 1'b1;
          end
        end else begin
          clr_dec = 1'b1;
          if (valor == VALOR_W'(CONTADOR_MIN)) negado_d = 1'b1;
          else                                 passo_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      espera_q <= '0;
      rr_dec_q <= 1'b0;
      rajada_q <= 1'b0;
      passo    <= 1'b0;
      sentido  <= 1'b0;
      zera     <= 1'b0;
      negado   <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      espera_q <= espera_d;
      rr_dec_q <= rr_dec_d;
      rajada_q <= rajada_d;
      passo    <= passo_d;
      sentido  <= sentido_d;
      zera     <= zera_d;
      negado   <= negado_d;
      ocupado  <= (estado_d != IDLE);
    end
  end

endmodule

// File: doc/controlador_contador.md
# controlador_contador

Sequencing and arbitration controller for the two-digit BCD 0–99 counter. It collects increment, decrement and clear requests and emits one-cycle step or clear strobes, at most one operation at a time. Before each step it checks the counter's BCD value fed back to it, rejecting steps at 99 and at 00. It also runs the automatic refill burst, incrementing up to a target when the count falls low.

## Interface
- STEP_GAP, 1: idle cycles after each strobe before the next decision (min 1; covers counter feedback latency)
- REPOR_LIMIT, 5: refill triggers when value < REPOR_LIMIT (binary, 1..99)
- REPOR_TARGET, 25: refill stops when value == REPOR_TARGET (binary, REPOR_LIMIT..99)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_inc  in  1  increment request, level; rising edge counts
- req_dec  in  1  decrement request, level; rising edge counts
- req_zera  in  1  clear request, level; rising edge counts
- auto_repor  in  1  refill enable, level
- unid  in  4  counter units digit (BCD)
- dezena  in  4  counter tens digit (BCD)
- passo  out  1  one-cycle step strobe to counter
- sentido  out  1  step direction, 1 = increment; valid only with passo
- zera  out  1  one-cycle clear strobe to counter
- negado  out  1  one-cycle pulse: request rejected at a boundary
- ocupado  out  1  high in any state other than IDLE

## Operation
- Each request input is registered. A rising edge (1 now, 0 previous sample) sets that requester's pending flag. Pending flags are one deep: further edges while a flag is set are dropped.
- Value is computed as dezena*10 + unid, giving 7-bit binary. All limit comparisons use this value.
- FSM states: IDLE, STEP, CLEAR, REPOR, WAIT.
- IDLE priority, highest first:
  - pending zera: go to CLEAR.
  - auto_repor=1 and value < REPOR_LIMIT: go to REPOR.
  - pending inc/dec: arbitrated, go to STEP.
  - otherwise stay in IDLE.
- Inc/dec arbitration: round-robin when both are pending. The pointer resets to inc and toggles after each served or rejected grant.
- STEP (inc):
  - value == 99: negado=1, no passo.
  - otherwise passo=1, sentido=1.
  - Either way the inc pending flag is cleared.
- STEP (dec):
  - value == 0: negado=1.
  - otherwise passo=1, sentido=0.
  - Either way the dec pending flag is cleared.
- CLEAR: zera=1 for one cycle. Clears the zera, inc and dec pending flags, then goes to WAIT.
- REPOR: each visit issues passo=1, sentido=1, then goes to WAIT. From WAIT it returns to REPOR until value == REPOR_TARGET, then returns to IDLE.
- Inc/dec requests arriving during REPOR stay pending and are served after the burst.
- A zera edge during REPOR aborts the burst after the current WAIT and is served immediately. Auto-refill then retriggers if enabled.
- auto_repor falling during REPOR: the burst stops at the next WAIT exit.
- WAIT: lasts exactly STEP_GAP cycles, with no strobes. It then goes to REPOR if a burst is active, otherwise to IDLE.

## Timing
- Reset values: passo, sentido, zera, negado, ocupado all 0. State is IDLE, pending flags are 0, round-robin pointer is inc.
- Request sampled 1 at edge k (0 at k−1): pending set at edge k, STEP/CLEAR entered at edge k+1, strobe visible in cycle k+1..k+2. Latency is 2 edges from IDLE.
- All outputs are registered. passo, zera and negado are each exactly one cycle wide and mutually exclusive.
- Minimum spacing between strobes is STEP_GAP+1 cycles.
- An inc and a dec edge in the same cycle are both latched and served in consecutive operations, inc first after reset.
- Asserting reset mid-burst or mid-WAIT returns to IDLE asynchronously. No strobe is emitted in that cycle.

## Configuration
- CONTROLADOR_REPOR_EN defined: REPOR state, limit/target compare and burst logic are compiled in, as described above.
- Not defined: auto_repor is ignored (port kept), REPOR is unreachable and removed, REPOR_LIMIT and REPOR_TARGET are unused.

## Structure
- Shared package contador_pkg holds:
  - FSM state encoding constants.
  - CONTADOR_MAX = 99 and CONTADOR_MIN = 0.
  - BCD digit width (4).
- Sub-module detector_pedido: one register per requester giving edge detect plus a one-deep pending latch with a clear input. It is instantiated three times.
- BCD-to-binary value conversion is inline, not a separate module.

## Test plan
- Value 42, single req_inc edge: passo=1, sentido=1 two edges later for one cycle; ocupado high for 1+STEP_GAP cycles.
- Value 99 with req_inc edge: negado pulse, no passo. Value 00 with req_dec edge: negado pulse.
- req_inc and req_dec rising in the same cycle at value 50: inc strobe, then dec strobe STEP_GAP+1 cycles later.
- CONTROLADOR_REPOR_EN, auto_repor=1, value fed back from a model counter starting at 03: 22 consecutive inc strobes spaced STEP_GAP+1 cycles, stopping at 25.
- req_zera edge mid-burst at value 12: zera strobe after current WAIT, then the burst restarts from 00 and ends at 25.
- Reset asserted during WAIT of a burst: all outputs 0 immediately; no strobe after reset until a new request edge.
